// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data-memory port between the pipeline MEM stage
// (cpu_*) and a loader/debug requester (dbg_*). One access at a time:
// IDLE arbitrates and latches the request, ACCESS issues a single mem_en
// pulse and waits MEM_LAT cycles for read data, RESP pulses the winner's ack.
//
// Parameters
//   DW       data word width
//   AW       word address width
//   MEM_LAT  memory read latency in cycles, 1..4
// Ports
//   clk, rst                       clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata          pipeline request
//   cpu_ack/rdata                  pipeline completion pulse and read data
//   cpu_stall                      combinational freeze: cpu_req & ~cpu_ack
//   dbg_req/we/addr/wdata          debug request
//   dbg_ack/rdata                  debug completion pulse and read data
//   mem_en/we/addr/wdata, mem_rdata  shared memory side
module dmem_arbiter #(
   parameter int unsigned DW      = 16,
   parameter int unsigned AW      = 8,
   parameter int unsigned MEM_LAT = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic          cpu_ack,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_stall,
   input  logic          dbg_req,
   input  logic          dbg_we,
   input  logic [AW-1:0] dbg_addr,
   input  logic [DW-1:0] dbg_wdata,
   output logic          dbg_ack,
   output logic [DW-1:0] dbg_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   localparam int unsigned CW = 3;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [CW-1:0]   cnt;
   logic            lat_dbg;
   logic            last_dbg;
   logic            lat_we;
   logic [AW-1:0]   lat_addr;
   logic [DW-1:0]   lat_wdata;
   logic            any_req_c;
   logic            grant_dbg_c;
   logic [DW-1:0]   cap_c;

   // Sole requester wins; on a tie the one not served last wins.
   assign any_req_c   = cpu_req | dbg_req;
   assign grant_dbg_c = dbg_req & (~cpu_req | ~last_dbg);

   // Writes return zero as their completion word.
   assign cap_c = lat_we ? '0 : mem_rdata;

   // Memory address/data come straight from the latched request registers.
   assign mem_addr  = lat_addr;
   assign mem_wdata = lat_wdata;

   // Reset gate keeps every output low while rst is held.
   assign cpu_stall = cpu_req & ~cpu_ack & ~rst;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (any_req_c) state_nxt = ACCESS;
         ACCESS:  if (cnt == '0) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Request latch, latency counter, memory strobes and response registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt       <= '0;
         lat_dbg   <= 1'b0;
         last_dbg  <= 1'b1;
         lat_we    <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         cpu_ack   <= 1'b0;
         dbg_ack   <= 1'b0;
         cpu_rdata <= '0;
         dbg_rdata <= '0;
      end else begin
         mem_en  <= 1'b0;
         mem_we  <= 1'b0;
         cpu_ack <= 1'b0;
         dbg_ack <= 1'b0;
         unique case (state)
            IDLE: begin
               if (any_req_c) begin
                  lat_dbg   <= grant_dbg_c;
                  lat_we    <= grant_dbg_c ? dbg_we    : cpu_we;
                  lat_addr  <= grant_dbg_c ? dbg_addr  : cpu_addr;
                  lat_wdata <= grant_dbg_c ? dbg_wdata : cpu_wdata;
                  cnt       <= CW'(MEM_LAT - 1);
                  // Strobe lands in the first ACCESS cycle only.
                  mem_en    <= 1'b1;
                  mem_we    <= grant_dbg_c ? dbg_we : cpu_we;
               end
            end
            ACCESS: begin
               if (cnt == '0) begin
                  if (lat_dbg) begin
                     dbg_ack   <= 1'b1;
                     dbg_rdata <= cap_c;
                  end else begin
                     cpu_ack   <= 1'b1;
                     cpu_rdata <= cap_c;
                  end
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            RESP: begin
               last_dbg <= lat_dbg;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter. A per-cycle vector table
// covers single reads/writes; hand-written sequences cover tie alternation,
// reset abort and the MEM_LAT=1/4 latency sweep (extra DUT instances).
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req, cpu_we, dbg_req, dbg_we;
   logic [7:0]  cpu_addr, dbg_addr;
   logic [15:0] cpu_wdata, dbg_wdata, mem_rdata;

   logic        o2_cack, o2_dack, o2_stall, o2_en, o2_we;
   logic [15:0] o2_crd, o2_drd, o2_mwd;
   logic [7:0]  o2_maddr;
   logic        o1_cack, o1_dack, o1_stall, o1_en, o1_we;
   logic [15:0] o1_crd, o1_drd, o1_mwd;
   logic [7:0]  o1_maddr;
   logic        o4_cack, o4_dack, o4_stall, o4_en, o4_we;
   logic [15:0] o4_crd, o4_drd, o4_mwd;
   logic [7:0]  o4_maddr;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.DW(16), .AW(8), .MEM_LAT(2)) u2 (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(o2_cack), .cpu_rdata(o2_crd), .cpu_stall(o2_stall),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_ack(o2_dack), .dbg_rdata(o2_drd),
      .mem_en(o2_en), .mem_we(o2_we), .mem_addr(o2_maddr), .mem_wdata(o2_mwd),
      .mem_rdata(mem_rdata));

   dmem_arbiter #(.DW(16), .AW(8), .MEM_LAT(1)) u1 (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(o1_cack), .cpu_rdata(o1_crd), .cpu_stall(o1_stall),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_ack(o1_dack), .dbg_rdata(o1_drd),
      .mem_en(o1_en), .mem_we(o1_we), .mem_addr(o1_maddr), .mem_wdata(o1_mwd),
      .mem_rdata(mem_rdata));

   dmem_arbiter #(.DW(16), .AW(8), .MEM_LAT(4)) u4 (
      .clk(clk), .rst(rst),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_ack(o4_cack), .cpu_rdata(o4_crd), .cpu_stall(o4_stall),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_ack(o4_dack), .dbg_rdata(o4_drd),
      .mem_en(o4_en), .mem_we(o4_we), .mem_addr(o4_maddr), .mem_wdata(o4_mwd),
      .mem_rdata(mem_rdata));

   typedef struct {
      logic        creq, cwe;
      logic [7:0]  caddr;
      logic [15:0] cwd;
      logic        dreq, dwe;
      logic [7:0]  daddr;
      logic [15:0] dwd;
      logic [15:0] mrd;
      logic        en, we;
      logic [7:0]  maddr;
      logic [15:0] mwd;
      logic        cack;
      logic [15:0] crd;
      logic        dack;
      logic [15:0] drd;
      logic        stall;
   } vec_t;

   localparam int unsigned NV = 15;
   vec_t tbl [NV];

   function automatic vec_t mk(
      input logic creq, input logic cwe, input logic [7:0] caddr, input logic [15:0] cwd,
      input logic dreq, input logic dwe, input logic [7:0] daddr, input logic [15:0] dwd,
      input logic [15:0] mrd,
      input logic en, input logic we, input logic [7:0] maddr, input logic [15:0] mwd,
      input logic cack, input logic [15:0] crd, input logic dack, input logic [15:0] drd,
      input logic stall);
      vec_t v;
      v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
      v.dreq = dreq; v.dwe = dwe; v.daddr = daddr; v.dwd = dwd;
      v.mrd = mrd; v.en = en; v.we = we; v.maddr = maddr; v.mwd = mwd;
      v.cack = cack; v.crd = crd; v.dack = dack; v.drd = drd; v.stall = stall;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic creq, input logic cwe, input logic [7:0] caddr,
                        input logic dreq, input logic dwe, input logic [7:0] daddr,
                        input logic [15:0] mrd);
      cpu_req = creq; cpu_we = cwe; cpu_addr = caddr;
      dbg_req = dreq; dbg_we = dwe; dbg_addr = daddr;
      mem_rdata = mrd;
   endtask

   task automatic all_zero(input string tag);
      chk({tag, " mem_en"},    32'(o2_en),    32'h0);
      chk({tag, " mem_we"},    32'(o2_we),    32'h0);
      chk({tag, " cpu_ack"},   32'(o2_cack),  32'h0);
      chk({tag, " dbg_ack"},   32'(o2_dack),  32'h0);
      chk({tag, " cpu_rdata"}, 32'(o2_crd),   32'h0);
      chk({tag, " dbg_rdata"}, 32'(o2_drd),   32'h0);
      chk({tag, " cpu_stall"}, 32'(o2_stall), 32'h0);
      chk({tag, " mem_addr"},  32'(o2_maddr), 32'h0);
      chk({tag, " mem_wdata"}, 32'(o2_mwd),   32'h0);
   endtask

   initial begin
      //        creq we caddr  cwd      dreq we daddr dwd      mrd      en we maddr mwd    cack crd      dack drd      stall
      // CPU read 0x05 -> 0xBEEF; address and we change mid-access
      tbl[0]  = mk(1, 0, 8'h05, 16'h0, 0, 0, 8'h00, 16'h0,    16'h0000, 0, 0, 8'h00, 16'h0, 0, 16'h0000, 0, 16'h0000, 1);
      tbl[1]  = mk(1, 0, 8'h05, 16'h0, 0, 0, 8'h00, 16'h0,    16'hBEEF, 1, 0, 8'h05, 16'h0, 0, 16'h0000, 0, 16'h0000, 1);
      tbl[2]  = mk(1, 1, 8'h77, 16'h0, 0, 0, 8'h00, 16'h0,    16'hBEEF, 0, 0, 8'h00, 16'h0, 0, 16'h0000, 0, 16'h0000, 1);
      tbl[3]  = mk(1, 0, 8'h05, 16'h0, 0, 0, 8'h00, 16'h0,    16'hBEEF, 0, 0, 8'h00, 16'h0, 1, 16'hBEEF, 0, 16'h0000, 0);
      tbl[4]  = mk(0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0,    16'h0000, 0, 0, 8'h00, 16'h0, 0, 16'hBEEF, 0, 16'h0000, 0);
      // dbg read 0x33 -> 0xA5A5; cpu_rdata holds
      tbl[5]  = mk(0, 0, 8'h00, 16'h0, 1, 0, 8'h33, 16'h0,    16'h0000, 0, 0, 8'h00, 16'h0, 0, 16'hBEEF, 0, 16'h0000, 0);
      tbl[6]  = mk(0, 0, 8'h00, 16'h0, 1, 0, 8'h33, 16'h0,    16'hA5A5, 1, 0, 8'h33, 16'h0, 0, 16'hBEEF, 0, 16'h0000, 0);
      tbl[7]  = mk(0, 0, 8'h00, 16'h0, 1, 0, 8'h33, 16'h0,    16'hA5A5, 0, 0, 8'h00, 16'h0, 0, 16'hBEEF, 0, 16'h0000, 0);
      tbl[8]  = mk(0, 0, 8'h00, 16'h0, 1, 0, 8'h33, 16'h0,    16'hA5A5, 0, 0, 8'h00, 16'h0, 0, 16'hBEEF, 1, 16'hA5A5, 0);
      tbl[9]  = mk(0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0,    16'h0000, 0, 0, 8'h00, 16'h0, 0, 16'hBEEF, 0, 16'hA5A5, 0);
      // dbg write 0x0A <= 0x1234; completion word is zero despite mem_rdata
      tbl[10] = mk(0, 0, 8'h00, 16'h0, 1, 1, 8'h0A, 16'h1234, 16'hFFFF, 0, 0, 8'h00, 16'h0,    0, 16'hBEEF, 0, 16'hA5A5, 0);
      tbl[11] = mk(0, 0, 8'h00, 16'h0, 1, 1, 8'h0A, 16'h1234, 16'hFFFF, 1, 1, 8'h0A, 16'h1234, 0, 16'hBEEF, 0, 16'hA5A5, 0);
      tbl[12] = mk(0, 0, 8'h00, 16'h0, 1, 1, 8'h0A, 16'h1234, 16'hFFFF, 0, 0, 8'h00, 16'h0,    0, 16'hBEEF, 0, 16'hA5A5, 0);
      tbl[13] = mk(0, 0, 8'h00, 16'h0, 1, 1, 8'h0A, 16'h1234, 16'hFFFF, 0, 0, 8'h00, 16'h0,    0, 16'hBEEF, 1, 16'h0000, 0);
      tbl[14] = mk(0, 0, 8'h00, 16'h0, 0, 0, 8'h00, 16'h0,    16'h0000, 0, 0, 8'h00, 16'h0,    0, 16'hBEEF, 0, 16'h0000, 0);

      rst = 1'b1;
      cpu_wdata = '0; dbg_wdata = '0;
      drive(0, 0, 8'h00, 0, 0, 8'h00, 16'h0);
      repeat (2) @(posedge clk);
      #1;
      all_zero("reset");
      rst = 1'b0;

      // Table-driven single accesses
      for (int i = 0; i < int'(NV); i++) begin
         @(posedge clk); #1;
         drive(tbl[i].creq, tbl[i].cwe, tbl[i].caddr, tbl[i].dreq, tbl[i].dwe, tbl[i].daddr, tbl[i].mrd);
         cpu_wdata = tbl[i].cwd; dbg_wdata = tbl[i].dwd;
         #3;
         chk($sformatf("v%0d mem_en", i),    32'(o2_en),    32'(tbl[i].en));
         chk($sformatf("v%0d mem_we", i),    32'(o2_we),    32'(tbl[i].we));
         if (tbl[i].en) begin
            chk($sformatf("v%0d mem_addr", i),  32'(o2_maddr), 32'(tbl[i].maddr));
            chk($sformatf("v%0d mem_wdata", i), 32'(o2_mwd),   32'(tbl[i].mwd));
         end
         chk($sformatf("v%0d cpu_ack", i),   32'(o2_cack),  32'(tbl[i].cack));
         chk($sformatf("v%0d cpu_rdata", i), 32'(o2_crd),   32'(tbl[i].crd));
         chk($sformatf("v%0d dbg_ack", i),   32'(o2_dack),  32'(tbl[i].dack));
         chk($sformatf("v%0d dbg_rdata", i), 32'(o2_drd),   32'(tbl[i].drd));
         chk($sformatf("v%0d cpu_stall", i), 32'(o2_stall), 32'(tbl[i].stall));
      end

      // Tie with both requests held: last served is dbg, so cpu, dbg, cpu
      cpu_wdata = '0; dbg_wdata = '0;
      for (int c = 0; c <= 12; c++) begin
         @(posedge clk); #1;
         if (c < 12) drive(1, 0, 8'h21, 1, 0, 8'h31, 16'hCAFE);
         else        drive(0, 0, 8'h00, 0, 0, 8'h00, 16'h0);
         #3;
         chk($sformatf("tie c%0d cpu_ack", c), 32'(o2_cack), 32'(c == 3 || c == 11));
         chk($sformatf("tie c%0d dbg_ack", c), 32'(o2_dack), 32'(c == 7));
         chk($sformatf("tie c%0d mem_en", c),  32'(o2_en),   32'(c == 1 || c == 5 || c == 9));
         if (c == 1 || c == 9) chk($sformatf("tie c%0d mem_addr", c), 32'(o2_maddr), 32'h21);
         if (c == 5)           chk($sformatf("tie c%0d mem_addr", c), 32'(o2_maddr), 32'h31);
      end
      chk("tie dbg_rdata", 32'(o2_drd), 32'hCAFE);

      // Reset in cycle 2 of a CPU read; last served is cpu before the reset
      @(posedge clk); #1; drive(1, 0, 8'h10, 0, 0, 8'h20, 16'h1111); #3;
      chk("rst r0 cpu_stall", 32'(o2_stall), 32'h1);
      @(posedge clk); #1; drive(1, 0, 8'h10, 1, 0, 8'h20, 16'h1111); #3;
      chk("rst r1 mem_en",   32'(o2_en),    32'h1);
      chk("rst r1 mem_addr", 32'(o2_maddr), 32'h10);
      @(posedge clk); #1; rst = 1'b1; #3;
      all_zero("rst r2");
      @(posedge clk); #1; rst = 1'b0; #3;
      chk("rst r3 cpu_ack", 32'(o2_cack), 32'h0);
      chk("rst r3 mem_en",  32'(o2_en),   32'h0);
      @(posedge clk); #4;
      chk("rst r4 mem_en",   32'(o2_en),    32'h1);
      chk("rst r4 mem_addr", 32'(o2_maddr), 32'h10);
      @(posedge clk); #4;
      chk("rst r5 mem_en",  32'(o2_en),   32'h0);
      chk("rst r5 cpu_ack", 32'(o2_cack), 32'h0);
      @(posedge clk); #4;
      chk("rst r6 cpu_ack",   32'(o2_cack), 32'h1);
      chk("rst r6 cpu_rdata", 32'(o2_crd),  32'h1111);
      chk("rst r6 dbg_ack",   32'(o2_dack), 32'h0);
      @(posedge clk); #1; drive(0, 0, 8'h00, 0, 0, 8'h00, 16'h0);

      // Latency sweep over MEM_LAT = 1, 2, 4 with a held CPU read
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
      begin
         int first1 = 0, first2 = 0, first4 = 0;
         int en1 = 0, en2 = 0, en4 = 0, wr = 0;
         int dack_any = 0;
         for (int c = 0; c <= 6; c++) begin
            @(posedge clk); #1;
            if (c <= 5) drive(1, 0, 8'h42, 0, 0, 8'h00, 16'h5A5A);
            else        drive(0, 0, 8'h00, 0, 0, 8'h00, 16'h0);
            #3;
            if (c >= 1) begin
               if (c <= 2 && o1_en) begin en1++; if (o1_we || o1_maddr != 8'h42) wr++; end
               if (c <= 3 && o2_en) begin en2++; if (o2_we || o2_maddr != 8'h42) wr++; end
               if (c <= 5 && o4_en) begin en4++; if (o4_we || o4_maddr != 8'h42) wr++; end
               if (o1_cack && first1 == 0) first1 = c;
               if (o2_cack && first2 == 0) first2 = c;
               if (o4_cack && first4 == 0) first4 = c;
               if (o1_dack || o2_dack || o4_dack) dack_any++;
            end
         end
         chk("lat1 ack cycle", 32'(first1), 32'd2);
         chk("lat2 ack cycle", 32'(first2), 32'd3);
         chk("lat4 ack cycle", 32'(first4), 32'd5);
         chk("lat1 mem_en count", 32'(en1), 32'd1);
         chk("lat2 mem_en count", 32'(en2), 32'd1);
         chk("lat4 mem_en count", 32'(en4), 32'd1);
         chk("sweep bad strobe", 32'(wr), 32'd0);
         chk("sweep dbg_ack", 32'(dack_any), 32'd0);
         chk("lat1 cpu_rdata", 32'(o1_crd), 32'h5A5A);
         chk("lat4 cpu_rdata", 32'(o4_crd), 32'h5A5A);
         chk("lat1 dbg_rdata", 32'(o1_drd), 32'h0);
         chk("lat4 dbg_rdata", 32'(o4_drd), 32'h0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
